data_memory: RTL and testbench
==============================

Name: data_memory

Overview:
- Word-addressed data RAM for the 16-bit single-cycle RISC datapath; serves load/store instructions from the memory stage.
- Writes are synchronous on the rising clock edge.
- Reads are combinational, so loaded data is available in the same cycle.
- Asynchronous active-low reset clears the whole array.

Parameters:
- DATA_WIDTH, 16, width of each memory word and of the data ports.
- ADDR_BITS, 8, number of low address bits that index the array; depth = 2**ADDR_BITS = 256 words.

Ports:
- clock  input  1  system clock; all writes occur on its rising edge.
- reset_n  input  1  asynchronous active-low reset; clears every word to 0.
- mem_write  input  1  write enable, sampled on the rising edge of clock.
- address  input  16  word address; bits [ADDR_BITS-1:0] index the array.
- write_data  input  DATA_WIDTH  data stored when mem_write=1.
- read_data  output  DATA_WIDTH  combinational contents of the addressed word.
- address_error  output  1  combinational; 1 when address[15:ADDR_BITS] != 0.

Behaviour:
- Storage: array of 2**ADDR_BITS words of DATA_WIDTH bits.
- Reset:
  - reset_n=0 asynchronously forces every word to 0, regardless of clock.
  - While reset_n=0, writes are ignored and read_data=0 for any in-range address.
  - Reset asserted mid-operation overrides any write on the same edge.
  - Normal operation resumes on the first rising edge after reset_n returns to 1.
- Write:
  - On the rising edge of clock, with reset_n=1, mem_write=1 and address_error=0: mem[address[ADDR_BITS-1:0]] <= write_data.
  - Exactly one word is modified per write. Write latency is one edge.
- Read:
  - read_data = mem[address[ADDR_BITS-1:0]] when address_error=0, otherwise 0.
  - Purely combinational: zero-cycle latency, no read enable.
  - Read is independent of mem_write.
- Read-during-write, same address: before the edge read_data shows the old value; immediately after the edge it shows write_data. No bypass from write_data to read_data.
- Out-of-range address (any of bits [15:ADDR_BITS] set):
  - address_error=1 and read_data=0.
  - The write is suppressed; no aliasing into the array.
- mem_write=0: array unchanged on every edge.
- X/undriven address or write_data while mem_write=0 must not corrupt the array.
- Boundaries:
  - Address 0 and address 2**ADDR_BITS-1 are both valid.
  - Address 2**ADDR_BITS is the first out-of-range address.
- No output registers; address_error and read_data change whenever address changes.

Test Plan:
- Basic write/read:
  - Stimulus: reset_n pulse low, release; on a negedge drive mem_write=1, address=0x0000, write_data=42.
  - Response: after the next posedge, with mem_write=0 and address=0x0000, read_data=42 and address_error=0.
- Reset clears:
  - Stimulus: write 0xBEEF to address 0x0010, then drive reset_n=0 asynchronously between edges.
  - Response: read_data at 0x0010 becomes 0 immediately, with no clock edge needed. A write attempted while reset_n=0 leaves it 0.
- Write-enable gating:
  - Stimulus: address 0x0005 holds 0x1111; drive write_data=0x2222 with mem_write=0 across 3 edges.
  - Response: read_data stays 0x1111.
- Top-of-range and out-of-range:
  - Stimulus: write 0xFFFF to 0x00FF; then attempt to write 0x1234 to 0x0100.
  - Response: 0x00FF reads 0xFFFF. 0x0100 gives address_error=1 and read_data=0. Address 0x0000 is unchanged (no alias).
- Read-during-write:
  - Stimulus: address 0x0020 holds 0x0007; set mem_write=1, write_data=0x0009.
  - Response: read_data=0x0007 before the posedge and 0x0009 after it.
- Multi-address independence:
  - Stimulus: write 1, 2, 3 to addresses 0x0001, 0x0002, 0x0003 on consecutive cycles.
  - Response: each address reads back its own value; neighbouring words are unaffected.

Source files
------------

// File: rtl/data_memory.sv
// Word-addressed data RAM for the 16-bit single-cycle RISC datapath.
// Synchronous write, combinational read, asynchronous clear of the whole array.
module data_memory #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_BITS  = 8
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  mem_write,
    input  logic [15:0]           address,
    input  logic [DATA_WIDTH-1:0] write_data,
    output logic [DATA_WIDTH-1:0] read_data,
    output logic                  address_error
);

    localparam int DEPTH = 1 << ADDR_BITS;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_BITS-1:0]  index;
    logic                  write_en;

    assign index         = address[ADDR_BITS-1:0];
    assign address_error = (address[15:ADDR_BITS] != '0);

    // Out-of-range addresses must never alias into the array.
    assign write_en = mem_write && !address_error;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (write_en) begin
            mem[index] <= write_data;
        end
    end

    // No bypass: a same-address write only becomes visible after the edge.
    assign read_data = address_error ? '0 : mem[index];

endmodule

// File: tb/tb_data_memory.sv
// Directed and randomized bench for data_memory against an array reference model.
module tb_data_memory;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        mem_write;
    logic [15:0] address;
    logic [15:0] write_data;
    logic [15:0] read_data;
    logic        address_error;

    int checks   = 0;
    int failures = 0;

    logic [15:0] ref_mem [256];

    data_memory #(.DATA_WIDTH(16), .ADDR_BITS(8)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .mem_write    (mem_write),
        .address      (address),
        .write_data   (write_data),
        .read_data    (read_data),
        .address_error(address_error)
    );

    always #5 clock = ~clock;

    function automatic void model_clear();
        for (int i = 0; i < 256; i++) ref_mem[i] = 16'h0000;
    endfunction

    // Drive an address, let the combinational read settle, compare against the model.
    task automatic check_rd(input string tag, input logic [15:0] addr);
        logic [15:0] exp_data;
        logic        exp_err;
        exp_err  = (addr > 16'd255);
        exp_data = exp_err ? 16'h0000 : ref_mem[addr[7:0]];
        address  = addr;
        #1;
        checks++;
        assert (read_data === exp_data) else begin
            failures++;
            $error("FAIL %s data addr=%h observed=%h expected=%h", tag, addr, read_data, exp_data);
        end
        checks++;
        assert (address_error === exp_err) else begin
            failures++;
            $error("FAIL %s addr_err addr=%h observed=%b expected=%b", tag, addr, address_error, exp_err);
        end
    endtask

    task automatic wr(input logic [15:0] addr, input logic [15:0] data);
        @(negedge clock);
        mem_write  = 1'b1;
        address    = addr;
        write_data = data;
        @(posedge clock);
        if (reset_n && addr < 16'd256) ref_mem[addr[7:0]] = data;
        #1;
        mem_write = 1'b0;
    endtask

    initial begin
        logic [15:0] a;
        logic [15:0] d;
        logic        we;

        model_clear();
        reset_n    = 1'b0;
        mem_write  = 1'b0;
        address    = 16'h0000;
        write_data = 16'h0000;
        #12;
        check_rd("reset_addr0", 16'h0000);
        check_rd("reset_top", 16'h00FF);
        @(negedge clock);
        reset_n = 1'b1;

        // Basic write/read
        wr(16'h0000, 16'd42);
        check_rd("basic", 16'h0000);

        // Asynchronous reset clears, and writes during reset are ignored
        wr(16'h0010, 16'hBEEF);
        check_rd("beef_written", 16'h0010);
        #2;
        reset_n = 1'b0;
        model_clear();
        check_rd("async_clear", 16'h0010);
        check_rd("async_clear_a0", 16'h0000);
        @(negedge clock);
        mem_write  = 1'b1;
        address    = 16'h0010;
        write_data = 16'h5555;
        @(posedge clock);
        #1;
        mem_write = 1'b0;
        check_rd("write_in_reset", 16'h0010);
        @(negedge clock);
        reset_n = 1'b1;

        // Write-enable gating, including undriven inputs while disabled
        wr(16'h0005, 16'h1111);
        @(negedge clock);
        mem_write  = 1'b0;
        address    = 16'h0005;
        write_data = 16'h2222;
        repeat (3) @(posedge clock);
        #1;
        check_rd("we_gating", 16'h0005);
        @(negedge clock);
        address    = 'x;
        write_data = 'x;
        @(posedge clock);
        #1;
        check_rd("x_inputs_5", 16'h0005);
        check_rd("x_inputs_0", 16'h0000);

        // Top-of-range and out-of-range
        wr(16'h00FF, 16'hFFFF);
        wr(16'h0100, 16'h1234);
        check_rd("top_valid", 16'h00FF);
        check_rd("first_oor", 16'h0100);
        check_rd("no_alias", 16'h0000);
        check_rd("oor_ffff", 16'hFFFF);

        // Read-during-write on the same address
        wr(16'h0020, 16'h0007);
        @(negedge clock);
        mem_write  = 1'b1;
        address    = 16'h0020;
        write_data = 16'h0009;
        check_rd("rdw_before", 16'h0020);
        @(posedge clock);
        ref_mem[8'h20] = 16'h0009;
        check_rd("rdw_after", 16'h0020);
        @(negedge clock);
        mem_write = 1'b0;

        // Multi-address independence
        wr(16'h0001, 16'd1);
        wr(16'h0002, 16'd2);
        wr(16'h0003, 16'd3);
        for (int i = 0; i <= 4; i++) check_rd("multi", 16'(i));

        // Randomized traffic against the model
        for (int n = 0; n < 300; n++) begin
            we = ($urandom_range(0, 1) == 1);
            a  = ($urandom_range(0, 4) == 0) ? 16'($urandom) : 16'($urandom_range(0, 255));
            d  = 16'($urandom);
            @(negedge clock);
            mem_write  = we;
            address    = a;
            write_data = d;
            check_rd("rand_pre", a);
            @(posedge clock);
            if (we && a < 16'd256) ref_mem[a[7:0]] = d;
            check_rd("rand_post", a);
        end
        @(negedge clock);
        mem_write = 1'b0;
        for (int i = 0; i < 256; i++) check_rd("sweep", 16'(i));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
